// File: rtl/stepper_sequencer_if.sv
// Host-side command/status bundle for the stepper sequencer.
// The sequencer connects to the slave modport and the host to the master modport.
interface stepper_sequencer_if #(
   parameter int PERIOD_W = 24,
   parameter int STEPS_W  = 16,
   parameter int POS_W    = 32
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [STEPS_W-1:0]  cmd_steps;
   logic [PERIOD_W-1:0] cmd_period;
   logic                cmd_dir;
   logic                cmd_half;
   logic                abort;
   logic                pos_zero;
   logic                busy;
   logic                done;
   logic                aborted;
   logic [POS_W-1:0]    position;
   logic [3:0]          drive;

   modport master (
      output cmd_valid, cmd_steps, cmd_period, cmd_dir, cmd_half, abort, pos_zero,
      input  cmd_ready, busy, done, aborted, position, drive
   );

   modport slave (
      input  cmd_valid, cmd_steps, cmd_period, cmd_dir, cmd_half, abort, pos_zero,
      output cmd_ready, busy, done, aborted, position, drive
   );
endinterface

// File: rtl/stepper_sequencer.sv
// 4-phase unipolar stepper pattern generator: runs a latched move command and
// tracks the absolute rotor position in half-step units.
module stepper_sequencer #(
   parameter int PERIOD_W = 24,
   parameter int STEPS_W  = 16,
   parameter int POS_W    = 32
) (
   input logic                clk,
   input logic                rst,
   stepper_sequencer_if.slave bus
);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LAUNCH = 2'd1;
   localparam logic [1:0] S_STEP   = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [2:0]          idx_q, idx_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic [STEPS_W-1:0]  steps_q, steps_d;
   logic [PERIOD_W-1:0] per_q, per_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                dir_q, dir_d;
   logic                half_q, half_d;
   logic [3:0]          drive_q, drive_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;

   logic [2:0]          step_mag;
   logic [2:0]          idx_step;
   logic [POS_W-1:0]    pos_step;
   logic                issue;
   logic                finish;

   function automatic logic [3:0] phase(input logic [2:0] i);
      logic [3:0] p;
      case (i)
         3'd0:    p = 4'b1000;
         3'd1:    p = 4'b1100;
         3'd2:    p = 4'b0100;
         3'd3:    p = 4'b0110;
         3'd4:    p = 4'b0010;
         3'd5:    p = 4'b0011;
         3'd6:    p = 4'b0001;
         default: p = 4'b1001;
      endcase
      return p;
   endfunction

   // Full-step from an even (one-coil) index moves by one to reach a two-coil entry.
   always_comb begin
      step_mag = (!half_q && idx_q[0]) ? 3'd2 : 3'd1;
      idx_step = dir_q ? (idx_q + step_mag) : (idx_q - step_mag);
      pos_step = dir_q ? (pos_q + {{(POS_W-3){1'b0}}, step_mag})
                       : (pos_q - {{(POS_W-3){1'b0}}, step_mag});
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pos_d     = pos_q;
      steps_d   = steps_q;
      per_d     = per_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      half_d    = half_q;
      drive_d   = drive_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      aborted_d = aborted_q;
      issue     = 1'b0;
      finish    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.pos_zero) pos_d = '0;
            if (bus.cmd_valid) begin
               steps_d   = bus.cmd_steps;
               per_d     = (bus.cmd_period < PERIOD_W'(2)) ? PERIOD_W'(2) : bus.cmd_period;
               dir_d     = bus.cmd_dir;
               half_d    = bus.cmd_half;
               aborted_d = 1'b0;
               busy_d    = (bus.cmd_steps != '0);
               state_d   = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            if (steps_q == '0) finish = 1'b1;
            else               issue  = 1'b1;
         end
         S_STEP: begin
            if (bus.abort) begin
               finish    = 1'b1;
               aborted_d = 1'b1;
            end else if (cnt_q == PERIOD_W'(1)) begin
               if (steps_q == '0) finish = 1'b1;
               else               issue  = 1'b1;
            end else begin
               cnt_d = cnt_q - PERIOD_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (issue) begin
         idx_d   = idx_step;
         pos_d   = pos_step;
         drive_d = phase(idx_step);
         steps_d = steps_q - STEPS_W'(1);
         cnt_d   = per_q;
         state_d = S_STEP;
      end
      if (finish) begin
         drive_d = '0;
         done_d  = 1'b1;
         busy_d  = 1'b0;
         cnt_d   = '0;
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         pos_q     <= '0;
         steps_q   <= '0;
         per_q     <= '0;
         cnt_q     <= '0;
         dir_q     <= 1'b0;
         half_q    <= 1'b0;
         drive_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pos_q     <= pos_d;
         steps_q   <= steps_d;
         per_q     <= per_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         half_q    <= half_d;
         drive_q   <= drive_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.aborted   = aborted_q;
   assign bus.position  = pos_q;
   assign bus.drive     = drive_q;
endmodule

// File: tb/tb_stepper_sequencer.sv
// Directed bench for stepper_sequencer: hand-computed drive/position/status
// at each edge of full-step, half-step, clamp, abort, back-to-back and reset moves.
module tb_stepper_sequencer;
   logic clk;
   logic rst;
   int   tests;
   int   fails;

   stepper_sequencer_if bus ();

   stepper_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp)
      else begin
         fails++;
         $error("FAIL %s: got %0h, required %0h", tag, got, exp);
      end
   endtask

   // Presents one command for exactly one edge (E0); returns at E0+1.
   task automatic issue(input int steps, input int period, input logic dir, input logic half);
      bus.cmd_steps  = 16'(steps);
      bus.cmd_period = 24'(period);
      bus.cmd_dir    = dir;
      bus.cmd_half   = half;
      bus.cmd_valid  = 1'b1;
      tick(1);
      bus.cmd_valid  = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_steps  = '0;
      bus.cmd_period = '0;
      bus.cmd_dir    = 1'b0;
      bus.cmd_half   = 1'b0;
      bus.abort      = 1'b0;
      bus.pos_zero   = 1'b0;
      tick(2);
      rst = 1'b0;

      check("rst_drive", 32'(bus.drive), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      check("rst_aborted", 32'(bus.aborted), 32'h0);
      check("rst_position", bus.position, 32'h0);
      check("rst_ready", 32'(bus.cmd_ready), 32'h1);

      // Full-step forward, 3 steps, P=4, from idx 0
      issue(3, 4, 1'b1, 1'b0);
      tick(1);
      check("fs_e1_drive", 32'(bus.drive), 32'hC);
      check("fs_e1_busy", 32'(bus.busy), 32'h1);
      check("fs_e1_ready", 32'(bus.cmd_ready), 32'h0);
      tick(4);
      check("fs_e5_drive", 32'(bus.drive), 32'h6);
      tick(4);
      check("fs_e9_drive", 32'(bus.drive), 32'h3);
      tick(3);
      check("fs_e12_done", 32'(bus.done), 32'h0);
      tick(1);
      check("fs_e13_drive", 32'(bus.drive), 32'h0);
      check("fs_e13_done", 32'(bus.done), 32'h1);
      check("fs_e13_pos", bus.position, 32'd5);
      check("fs_e13_busy", 32'(bus.busy), 32'h0);
      check("fs_e13_ready", 32'(bus.cmd_ready), 32'h1);
      tick(1);
      check("fs_done_pulse", 32'(bus.done), 32'h0);

      // Half-step reverse, 4 steps, P=2, from idx 5
      issue(4, 2, 1'b0, 1'b1);
      tick(1);
      check("hs_e1_drive", 32'(bus.drive), 32'h2);
      tick(2);
      check("hs_e3_drive", 32'(bus.drive), 32'h6);
      tick(2);
      check("hs_e5_drive", 32'(bus.drive), 32'h4);
      tick(2);
      check("hs_e7_drive", 32'(bus.drive), 32'hC);
      tick(2);
      check("hs_e9_done", 32'(bus.done), 32'h1);
      check("hs_e9_drive", 32'(bus.drive), 32'h0);
      check("hs_e9_pos", bus.position, 32'd1);

      // Period 0 clamps to 2: half-step forward from idx 1
      issue(2, 0, 1'b1, 1'b1);
      tick(1);
      check("clamp_e1_drive", 32'(bus.drive), 32'h4);
      check("clamp_e1_pos", bus.position, 32'd2);
      tick(1);
      check("clamp_e2_drive", 32'(bus.drive), 32'h4);
      tick(1);
      check("clamp_e3_drive", 32'(bus.drive), 32'h6);
      check("clamp_e3_pos", bus.position, 32'd3);
      tick(1);
      check("clamp_e4_done", 32'(bus.done), 32'h0);
      tick(1);
      check("clamp_e5_done", 32'(bus.done), 32'h1);

      // Zero-step command
      issue(0, 5, 1'b1, 1'b0);
      check("zero_e0_drive", 32'(bus.drive), 32'h0);
      check("zero_e0_busy", 32'(bus.busy), 32'h0);
      tick(1);
      check("zero_e1_done", 32'(bus.done), 32'h1);
      check("zero_e1_drive", 32'(bus.drive), 32'h0);
      check("zero_e1_busy", 32'(bus.busy), 32'h0);
      check("zero_e1_pos", bus.position, 32'd3);

      // Full-step reverse from idx 3, aborted after three steps; pos_zero ignored while busy
      issue(100, 10, 1'b0, 1'b0);
      tick(1);
      check("ab_e1_drive", 32'(bus.drive), 32'hC);
      check("ab_e1_pos", bus.position, 32'd1);
      tick(10);
      check("ab_e11_drive", 32'(bus.drive), 32'h9);
      check("ab_e11_pos", bus.position, 32'hFFFF_FFFF);
      bus.pos_zero = 1'b1;
      tick(1);
      bus.pos_zero = 1'b0;
      check("ab_pz_busy_pos", bus.position, 32'hFFFF_FFFF);
      tick(9);
      check("ab_e21_drive", 32'(bus.drive), 32'h3);
      tick(4);
      bus.abort = 1'b1;
      tick(1);
      bus.abort = 1'b0;
      check("ab_e26_drive", 32'(bus.drive), 32'h0);
      check("ab_e26_done", 32'(bus.done), 32'h1);
      check("ab_e26_aborted", 32'(bus.aborted), 32'h1);
      check("ab_e26_busy", 32'(bus.busy), 32'h0);
      check("ab_e26_pos", bus.position, 32'hFFFF_FFFD);
      bus.abort = 1'b1;
      tick(1);
      bus.abort = 1'b0;
      check("ab_sticky", 32'(bus.aborted), 32'h1);
      check("ab_idle_abort_done", 32'(bus.done), 32'h0);

      // Back-to-back with cmd_valid held: half-step forward, 1 step, P=3, from idx 5
      bus.cmd_steps  = 16'd1;
      bus.cmd_period = 24'd3;
      bus.cmd_dir    = 1'b1;
      bus.cmd_half   = 1'b1;
      bus.cmd_valid  = 1'b1;
      tick(1);
      check("b2b_aborted_clr", 32'(bus.aborted), 32'h0);
      tick(1);
      check("b2b_e1_drive", 32'(bus.drive), 32'h1);
      check("b2b_e1_pos", bus.position, 32'hFFFF_FFFE);
      tick(3);
      check("b2b_e4_done", 32'(bus.done), 32'h1);
      check("b2b_e4_busy", 32'(bus.busy), 32'h0);
      check("b2b_e4_ready", 32'(bus.cmd_ready), 32'h1);
      tick(1);
      bus.cmd_valid = 1'b0;
      check("b2b_acc_busy", 32'(bus.busy), 32'h1);
      check("b2b_acc_ready", 32'(bus.cmd_ready), 32'h0);
      check("b2b_acc_done", 32'(bus.done), 32'h0);
      tick(1);
      check("b2b2_e1_drive", 32'(bus.drive), 32'h9);
      check("b2b2_e1_pos", bus.position, 32'hFFFF_FFFF);
      tick(3);
      check("b2b2_e4_done", 32'(bus.done), 32'h1);
      bus.pos_zero = 1'b1;
      tick(1);
      bus.pos_zero = 1'b0;
      check("pz_idle_pos", bus.position, 32'h0);

      // Reset mid-move with a handshake held during reset; idx 7 full-step forward
      issue(100, 2, 1'b1, 1'b0);
      tick(1);
      check("rm_e1_drive", 32'(bus.drive), 32'hC);
      tick(6);
      rst = 1'b1;
      bus.cmd_steps = 16'd5;
      bus.cmd_valid = 1'b1;
      tick(1);
      check("rm_drive", 32'(bus.drive), 32'h0);
      check("rm_busy", 32'(bus.busy), 32'h0);
      check("rm_pos", bus.position, 32'h0);
      tick(1);
      check("rm_hs_ignored", 32'(bus.busy), 32'h0);
      rst = 1'b0;
      bus.cmd_valid = 1'b0;
      tick(1);
      issue(1, 4, 1'b1, 1'b0);
      tick(1);
      check("post_rst_drive", 32'(bus.drive), 32'hC);
      check("post_rst_pos", bus.position, 32'd1);
      tick(4);
      check("post_rst_done", 32'(bus.done), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/stepper_sequencer.md
Name: stepper_sequencer

Overview:
- Generates the 4-phase coil drive patterns for a unipolar stepper motor from a move command: step count, direction, full/half-step mode and step period.
- drive[3:0] feeds the existing step_drive pulse-width limiter, which sits between this block and the coil FETs.
- Tracks absolute rotor position in half-step units and reports busy/done to the host register interface.

Parameters:
- PERIOD_W, 24, width of step period in clk cycles (100 MHz clk).
- STEPS_W, 16, width of commanded step count.
- POS_W, 32, width of signed position counter.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous reset, active high
- cmd_valid  in  1  move command present
- cmd_ready  out  1  high whenever state is IDLE
- cmd_steps  in  STEPS_W  number of steps to issue
- cmd_period  in  PERIOD_W  clk cycles per step; values 0 and 1 are treated as 2
- cmd_dir  in  1  1 = forward (phase index +), 0 = reverse
- cmd_half  in  1  1 = half-step, 0 = full-step (two-coil-on)
- abort  in  1  terminate the move in progress
- pos_zero  in  1  clear position; honoured only in IDLE
- busy  out  1  move in progress
- done  out  1  one-cycle pulse at end of move
- aborted  out  1  sticky; set with done on an abort, cleared at next accept
- position  out  POS_W  signed half-step position
- drive  out  4  coil pattern to step_drive

Behaviour:
- Reset values:
  - state IDLE, drive=0, busy=0, done=0, aborted=0, position=0.
  - Phase index idx (3 bit) = 0, step counter = 0, period counter = 0.
- Phase table, idx 0..7 = 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001 (bit3..bit0 = D,C,B,A).
- Accept happens when cmd_valid & cmd_ready are both high at a clk edge (E0). All command fields are latched at E0; later input changes are ignored.
- cmd_steps=0: no motion, drive stays 0. At E1, done=1 and busy=0, and state returns to IDLE.
- Otherwise the block enters STEP at E1:
  - busy=1, the first step is issued, drive=table[new idx].
  - Each later step is issued every P cycles (P = max(cmd_period, 2)). Step k appears at E1+(k-1)·P.
- Step increment:
  - Half-step: idx ±1.
  - Full-step: idx ±2, except when the current idx is even. In that case the step is ±1, which aligns idx to an odd (two-coil) entry. That alignment step counts as one commanded step.
  - idx wraps mod 8.
  - position changes by the same signed delta as idx in the same cycle. It wraps two's complement with no saturation.
- Completion: after the last step has been held P cycles (at E1+N·P):
  - drive=0, done=1 for one cycle, busy=0, return to IDLE.
  - cmd_ready is high in that same cycle, so back-to-back commands are allowed.
- idx and position persist across moves. Drive always de-energises between moves.
- Abort:
  - If abort is sampled high in STEP: at the next edge drive=0, done=1, aborted=1, busy=0, state IDLE.
  - Steps already issued remain counted in position. If abort coincides with a scheduled step edge, that step is not issued.
  - abort in IDLE is ignored.
- pos_zero:
  - In IDLE, position=0 at the next edge, and idx is unchanged.
  - While busy, pos_zero is ignored.
  - If pos_zero coincides with accept, the clear is applied first; the first step delta then adds to 0.
- rst mid-move: the next edge forces all reset values (drive=0 immediately registered), and the move is discarded. Command handshakes sampled while rst is high are ignored.
- All outputs are registered except cmd_ready (= state==IDLE, combinational from state).

Test Plan:
- Full-step forward: reset, cmd_steps=3, P=4, dir=1, half=0. Required response:
  - drive=1100 at E1, 0110 at E5, 0011 at E9.
  - drive=0 with done=1 at E13; position=5, busy=0 at E13.
- Half-step reverse from idx=5 (after the test above): steps=4, P=2, dir=0, half=1. Required response:
  - drive sequence 0010, 0110, 0100, 1100 at E1, E3, E5, E7; done at E9; position=1.
- Period clamp and zero steps:
  - cmd_period=0, steps=2 gives steps 2 cycles apart.
  - cmd_steps=0 gives done at E1, drive never nonzero, position unchanged.
- Abort: steps=100, P=10, abort asserted for one cycle at E25. Required response:
  - drive=0, done=1, aborted=1 at E26; position = ±3 (three steps issued); next accept clears aborted.
- Back-to-back and pos_zero: a second command with cmd_valid held high is accepted in the done cycle, and busy drops only for that cycle. Also required:
  - pos_zero while busy leaves position unchanged.
  - pos_zero in IDLE clears it next cycle.
- Reset mid-move: rst high at E7 of a long move. Required response:
  - drive=0, busy=0, position=0, idx=0 after E8.
  - A new command after reset starts from table[1] in full-step mode.
